// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory request per load/store, formats load data
// and produces the memory pipeline register. Optional response timeout: MEM_RESP_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_regf_we,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic        i_ext_stall,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        dmem_stall,
  output logic        o_valid,
  output logic [4:0]  o_rd_addr,
  output logic        o_regf_we,
  output logic [31:0] o_wb_data,
  output logic        o_misaligned,
  output logic        o_bus_error
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [1:0]  off;
  logic [4:0]  shamt;
  logic        is_h;
  logic        is_w;
  logic        misaligned;
  logic        mem_op;
  logic        req;
  logic        timeout;
  logic        adv;
  logic [3:0]  mask;
  logic [31:0] lane;
  logic [31:0] load_data;
  logic [31:0] hold_data;
  logic [31:0] wb_next;

  assign off        = i_addr[1:0];
  assign shamt      = {off, 3'b000};
  assign is_h       = (i_funct3[1:0] == 2'b01);
  assign is_w       = (i_funct3[1:0] == 2'b10);
  assign misaligned = (i_mem_read | i_mem_write) &
                      ((is_h & i_addr[0]) | (is_w & (i_addr[1:0] != 2'b00)));
  assign mem_op     = i_valid & (i_mem_read | i_mem_write) & ~misaligned;
  assign req        = (state == IDLE) & mem_op;

  always_comb begin
    mask = 4'b1111;
    case (i_funct3[1:0])
      2'b00:   mask = 4'b0001 << off;
      2'b01:   mask = 4'b0011 << off;
      default: mask = 4'b1111;
    endcase
  end

  assign dmem_addr  = {i_addr[31:2], 2'b00};
  assign dmem_rmask = (req & i_mem_read)  ? mask : 4'b0000;
  assign dmem_wmask = (req & i_mem_write) ? mask : 4'b0000;
  assign dmem_wdata = is_w ? i_wdata : (i_wdata << shamt);

  assign lane = dmem_rdata >> shamt;

  always_comb begin
    load_data = dmem_rdata;
    case (i_funct3)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'h0, lane[7:0]};
      3'b101:  load_data = {16'h0, lane[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

`ifdef MEM_RESP_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] wait_cnt;

  assign timeout = (state == WAIT) & ~dmem_resp & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Counts completed WAIT cycles; cleared whenever the FSM leaves or is outside WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state == WAIT) && !dmem_resp && !timeout) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign dmem_stall = req | ((state == WAIT) & ~dmem_resp & ~timeout);
  assign adv        = ~(i_ext_stall | dmem_stall);

  // In DONE the bus no longer carries the response, so the held copy is used.
  assign wb_next = (i_mem_read & ~misaligned) ?
                   ((state == DONE) ? hold_data : load_data) : i_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_data <= 32'h0;
    end else begin
      case (state)
        IDLE: if (mem_op) state <= WAIT;
        WAIT: begin
          if (dmem_resp) begin
            hold_data <= load_data;
            state     <= i_ext_stall ? DONE : IDLE;
          end else if (timeout) begin
            state <= IDLE;
          end
        end
        DONE:    if (!i_ext_stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid      <= 1'b0;
      o_rd_addr    <= 5'h0;
      o_regf_we    <= 1'b0;
      o_wb_data    <= 32'h0;
      o_misaligned <= 1'b0;
      o_bus_error  <= 1'b0;
    end else if (adv) begin
      o_valid      <= i_valid;
      o_rd_addr    <= i_rd_addr;
      o_regf_we    <= i_regf_we & ~misaligned & ~timeout;
      o_wb_data    <= wb_next;
      o_misaligned <= misaligned;
      o_bus_error  <= timeout;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads/stores/pass-throughs, stalls, reset and
// (with MEM_RESP_TIMEOUT_EN) the response timeout.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [4:0]  i_rd_addr;
  logic        i_regf_we;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [2:0]  i_funct3;
  logic        i_ext_stall;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_stall;
  logic        o_valid;
  logic [4:0]  o_rd_addr;
  logic        o_regf_we;
  logic [31:0] o_wb_data;
  logic        o_misaligned;
  logic        o_bus_error;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] wb;
    logic        mis;
    logic        berr;
    logic        chk_wb;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rd_addr(i_rd_addr), .i_regf_we(i_regf_we), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_funct3(i_funct3), .i_ext_stall(i_ext_stall),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .dmem_stall(dmem_stall), .o_valid(o_valid), .o_rd_addr(o_rd_addr),
    .o_regf_we(o_regf_we), .o_wb_data(o_wb_data), .o_misaligned(o_misaligned),
    .o_bus_error(o_bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: the pipeline register advances on an edge where no stall is present.
  always @(posedge clk) begin
    automatic logic strobe = !rst && i_valid && !(i_ext_stall || dmem_stall);
    #1;
    if (strobe) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_output", 32'd1, 32'd0);
      end else begin
        automatic exp_t e = exp_q.pop_front();
        check("sb_valid", {31'h0, o_valid}, 32'd1);
        check("sb_rd", {27'h0, o_rd_addr}, {27'h0, e.rd});
        check("sb_regf_we", {31'h0, o_regf_we}, {31'h0, e.we});
        check("sb_misaligned", {31'h0, o_misaligned}, {31'h0, e.mis});
        check("sb_bus_error", {31'h0, o_bus_error}, {31'h0, e.berr});
        if (e.chk_wb) check("sb_wb_data", o_wb_data, e.wb);
      end
    end
  end

  task automatic apply_stimulus(input logic v, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd, input logic we, input logic rd_en,
                                input logic wr_en, input logic [2:0] f3);
    i_valid     = v;
    i_addr      = addr;
    i_wdata     = wdata;
    i_rd_addr   = rd;
    i_regf_we   = we;
    i_mem_read  = rd_en;
    i_mem_write = wr_en;
    i_funct3    = f3;
    i_ext_stall = 1'b0;
    dmem_resp   = 1'b0;
  endtask

  task automatic push(input logic [4:0] rd, input logic we, input logic [31:0] wb,
                      input logic mis, input logic berr, input logic chk_wb);
    exp_t e;
    e.rd = rd; e.we = we; e.wb = wb; e.mis = mis; e.berr = berr; e.chk_wb = chk_wb;
    exp_q.push_back(e);
  endtask

  task automatic run_mem(input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic we, input logic rd_en, input logic wr_en,
                         input logic [2:0] f3, input logic [31:0] rdata, input int delay,
                         input int ext, input logic [31:0] exp_wb, input logic [3:0] exp_rmask,
                         input logic [3:0] exp_wmask, input logic [31:0] exp_wdata);
    int stall_cnt;
    int req_cnt;
    @(negedge clk);
    apply_stimulus(1'b1, addr, wdata, rd, we, rd_en, wr_en, f3);
    push(rd, we, exp_wb, 1'b0, 1'b0, 1'b1);
    #1;
    check("req_addr", dmem_addr, {addr[31:2], 2'b00});
    check("req_rmask", {28'h0, dmem_rmask}, {28'h0, exp_rmask});
    check("req_wmask", {28'h0, dmem_wmask}, {28'h0, exp_wmask});
    if (wr_en) check("req_wdata", dmem_wdata, exp_wdata);
    stall_cnt = dmem_stall ? 1 : 0;
    req_cnt   = 1;
    for (int k = 0; k < delay; k++) begin
      @(negedge clk); #1;
      if (dmem_stall) stall_cnt++;
      if ((dmem_rmask | dmem_wmask) != 4'b0000) req_cnt++;
    end
    check("stall_cycles", stall_cnt, delay + 1);
    @(negedge clk);
    dmem_resp   = 1'b1;
    dmem_rdata  = rdata;
    i_ext_stall = (ext > 0);
    #1;
    check("resp_stall", {31'h0, dmem_stall}, 32'd0);
    for (int k = 0; k < ext; k++) begin
      @(negedge clk);
      dmem_resp  = 1'b0;
      dmem_rdata = 32'h5A5A5A5A;
      #1;
      if (dmem_stall) stall_cnt++;
      if ((dmem_rmask | dmem_wmask) != 4'b0000) req_cnt++;
    end
    if (ext > 0) begin
      @(negedge clk);
      i_ext_stall = 1'b0;
      #1;
      if ((dmem_rmask | dmem_wmask) != 4'b0000) req_cnt++;
      check("done_no_stall", stall_cnt, delay + 1);
    end
    check("req_once", req_cnt, 1);
  endtask

  task automatic run_passthru(input logic [31:0] addr, input logic [4:0] rd, input logic we,
                              input logic rd_en, input logic wr_en, input logic [2:0] f3,
                              input logic exp_mis, input logic exp_we, input logic chk_wb);
    @(negedge clk);
    apply_stimulus(1'b1, addr, 32'h1111_2222, rd, we, rd_en, wr_en, f3);
    push(rd, exp_we, addr, exp_mis, 1'b0, chk_wb);
    #1;
    check("pass_stall", {31'h0, dmem_stall}, 32'd0);
    check("pass_masks", {24'h0, dmem_rmask, dmem_wmask}, 32'd0);
  endtask

  task automatic check_output(input string name, input logic [31:0] wb);
    check({name, "_valid"}, {31'h0, o_valid}, 32'd0);
    check({name, "_wb"}, o_wb_data, wb);
    check({name, "_stall"}, {31'h0, dmem_stall}, 32'd0);
    check({name, "_rmask"}, {28'h0, dmem_rmask}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    dmem_rdata = 32'h0;
    apply_stimulus(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("reset", 32'h0);
    check("reset_flags", {29'h0, o_regf_we, o_misaligned, o_bus_error}, 32'd0);

    // LW with a 3-cycle response delay.
    run_mem(32'h1000_0008, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 3'b010, 32'hDEADBEEF, 3, 0,
            32'hDEADBEEF, 4'b1111, 4'b0000, 32'h0);
    run_mem(32'h1000_0003, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 3'b000, 32'h80112233, 1, 0,
            32'hFFFFFF80, 4'b1000, 4'b0000, 32'h0);
    run_mem(32'h1000_0003, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b100, 32'h80112233, 1, 0,
            32'h00000080, 4'b1000, 4'b0000, 32'h0);
    run_mem(32'h1000_0002, 32'h0000ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001, 32'h0, 0, 0,
            32'h1000_0002, 4'b0000, 4'b1100, 32'hABCD0000);
    run_passthru(32'h1000_0002, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
    run_passthru(32'h1000_0001, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
    // LH whose response arrives under an external stall held 2 more cycles.
    run_mem(32'h2000_0002, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b001, 32'h80011234, 2, 2,
            32'hFFFF8001, 4'b1100, 4'b0000, 32'h0);
    run_mem(32'h2000_0000, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b101, 32'h1234F00D, 0, 0,
            32'h0000F00D, 4'b0011, 4'b0000, 32'h0);
    run_passthru(32'h1234_5678, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1);
    run_mem(32'h0000_0020, 32'hCAFEBABE, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0, 1, 0,
            32'h0000_0020, 4'b0000, 4'b1111, 32'hCAFEBABE);
    run_mem(32'h0000_0031, 32'h000000A5, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 0, 1,
            32'h0000_0031, 4'b0000, 4'b0010, 32'h0000A500);

    // Bubble carrying mem_read must not issue a request.
    @(negedge clk);
    apply_stimulus(1'b0, 32'h0000_0040, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010);
    #1;
    check("bubble_rmask", {28'h0, dmem_rmask}, 32'd0);
    check("bubble_stall", {31'h0, dmem_stall}, 32'd0);

    // Reset in WAIT, then a stray response while IDLE.
    @(negedge clk);
    apply_stimulus(1'b1, 32'h0000_0040, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_reset_wait", {31'h0, dmem_stall}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("after_reset", 32'h0);
    @(negedge clk);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h77777777;
    #1;
    check("late_resp_stall", {31'h0, dmem_stall}, 32'd0);
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    check_output("late_resp", 32'h0);
    run_passthru(32'h0BAD_F00D, 5'd10, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1);

`ifdef MEM_RESP_TIMEOUT_EN
    begin
      int stall_cnt;
      @(negedge clk);
      apply_stimulus(1'b1, 32'h0000_0080, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b010);
      push(5'd11, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      #1;
      stall_cnt = dmem_stall ? 1 : 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk); #1;
        if (!dmem_stall) break;
        stall_cnt++;
      end
      check("timeout_stall_cycles", stall_cnt, 4);
    end
`endif

    @(negedge clk);
    apply_stimulus(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory pipeline stage, directly downstream of execute. Consumes the execute pipeline register (ALU result/address, store data, rd, memory and writeback control).
- Issues one data-memory request per load/store and waits for the response. Aligns, masks and sign-extends load data.
- Produces the memory pipeline register consumed by writeback and by execute's forwarding path.
- Raises dmem_stall while a request is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before a bus error. Used only with MEM_RESP_TIMEOUT_EN.

Ports:
- clk in 1: clock.
- rst in 1: reset.
- i_valid in 1: execute register holds a real instruction.
- i_addr in 32: execute func_out. Memory address, or result for non-memory ops.
- i_wdata in 32: store data (forwarded rs2).
- i_rd_addr in 5: destination register.
- i_regf_we in 1: writeback enable.
- i_mem_read in 1: load.
- i_mem_write in 1: store.
- i_funct3 in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_ext_stall in 1: stall from non-memory sources (e.g. execute func_stall).
- dmem_addr out 32: word-aligned address, {i_addr[31:2],2'b00}.
- dmem_rmask out 4: read byte mask.
- dmem_wmask out 4: write byte mask.
- dmem_wdata out 32: lane-shifted store data.
- dmem_rdata in 32: read data.
- dmem_resp in 1: response strobe.
- dmem_stall out 1: memory stall to the hazard logic.
- o_valid out 1: registered valid.
- o_rd_addr out 5: registered rd.
- o_regf_we out 1: registered writeback enable.
- o_wb_data out 32: registered writeback data.
- o_misaligned out 1: registered misaligned-access flag.
- o_bus_error out 1: registered timeout flag. Tied 0 without MEM_RESP_TIMEOUT_EN.

Behaviour:
- Reset is synchronous, active-high.
  - All o_* outputs reset to 0; FSM goes to IDLE; dmem_rmask/wmask = 0; timeout counter = 0.
  - Reset mid-WAIT abandons the request. A dmem_resp arriving afterwards in IDLE is ignored.
- mem_op = i_valid & (i_mem_read | i_mem_write) & ~misaligned.
- misaligned = (H/HU & i_addr[0]) | (W & i_addr[1:0]!=0), on a load or store.
- Masks (off = i_addr[1:0]):
  - B/BU: 4'b0001<<off. H/HU: 4'b0011<<off. W: 4'b1111.
  - rmask is driven only for loads, wmask only for stores.
  - Masks are nonzero only in IDLE when mem_op is true (a one-cycle request pulse).
- Store data: dmem_wdata = i_wdata << (8*off) for B/H; unshifted for W.
- FSM:
  - IDLE: if mem_op, drive the request, set dmem_stall=1, go to WAIT. Otherwise dmem_stall=0.
  - WAIT: no request driven.
    - dmem_resp=0: dmem_stall=1, stay.
    - dmem_resp=1: capture the formatted load data into a hold register. dmem_stall=0 this cycle.
      - If i_ext_stall=0, go to IDLE; the pipeline register latches.
      - If i_ext_stall=1, go to DONE.
  - DONE: dmem_stall=0, no reissue.
    - Leave to IDLE when i_ext_stall=0; the pipeline register latches from the hold register.
- dmem_resp in the same cycle as the request is not supported. Earliest response is the cycle after the request.
- Load formatting (lane = dmem_rdata >> 8*off):
  - LB: sign-extend lane[7:0]. LBU: zero-extend lane[7:0].
  - LH: sign-extend lane[15:0]. LHU: zero-extend lane[15:0].
  - LW: dmem_rdata.
- Pipeline register advance: update when !(i_ext_stall | dmem_stall), else hold.
  - o_valid = i_valid.
  - o_rd_addr = i_rd_addr.
  - o_wb_data = formatted load data for loads, i_addr otherwise.
  - o_regf_we = i_regf_we & ~misaligned & ~bus_error.
  - o_misaligned = misaligned.
  - Non-memory ops pass through with zero added latency and no stall.
- Stores: o_wb_data = i_addr; o_regf_we = i_regf_we (0 from decode).
- i_valid=0 with mem_read set: no request is issued.

Optional Feature:
- Macro: MEM_RESP_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without dmem_resp: go to IDLE, dmem_stall=0, latch o_bus_error=1, o_regf_we=0. The counter clears on leaving WAIT.
- Undefined: no counter; WAIT waits indefinitely; o_bus_error constant 0.

Test Plan:
- LW, i_addr=0x1000_0008, dmem_resp after 3 cycles with rdata=0xDEADBEEF:
  - dmem_rmask=1111 for one cycle; dmem_addr=0x1000_0008.
  - dmem_stall high 4 cycles.
  - o_wb_data=0xDEADBEEF, o_regf_we=1.
- LB addr 0x...03, rdata=0x80112233 -> rmask=1000, o_wb_data=0xFFFFFF80. LBU same -> 0x00000080.
- SH addr 0x...02, wdata=0x0000ABCD -> wmask=1100, dmem_wdata=0xABCD0000, o_regf_we=0.
- LW addr 0x...02 -> no request, dmem_stall=0, o_misaligned=1, o_regf_we=0.
- LW with resp while i_ext_stall=1 for 2 more cycles -> FSM goes to DONE, no second request, data latched when the stall drops.
- Reset during WAIT, then a late dmem_resp -> outputs stay 0, no state change. With MEM_RESP_TIMEOUT_EN and TIMEOUT_CYCLES=4, no resp -> o_bus_error=1 after 4 WAIT cycles.
